// File: rtl/correction_sched.sv
// correction_sched: round-robin issue scheduler and qH owner for one correction_u
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid_i, req_C_i     per-requester operand valid and packed operands
//   req_ready_o              one-hot grant, combinational from req_valid_i
//   cfg_valid_i, cfg_qH_i    qH reload request and value
//   cfg_ready_o              high in the single cycle qH is loaded
//   cu_qH_o, cu_C_o, cu_T_i  correction unit qH, operand and result
//   rsp_valid_o, rsp_id_o    tagged result valid and originating requester
//   rsp_T_o                  result (cu_T_i passed through)
//   busy_o                   one or more operations in flight
module correction_sched #(
    parameter int LOGQ  = 64,
    parameter int LOGQH = 17,
    parameter int NREQ  = 4,
    parameter int LAT   = 3,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*LOGQ-1:0] req_C_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic                 cfg_valid_i,
    input  logic [LOGQH-1:0]     cfg_qH_i,
    output logic                 cfg_ready_o,
    output logic [LOGQH-1:0]     cu_qH_o,
    output logic [LOGQ-1:0]      cu_C_o,
    input  logic [LOGQ-1:0]      cu_T_i,
    output logic                 rsp_valid_o,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [LOGQ-1:0]      rsp_T_o,
    output logic                 busy_o
);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {UNCFG, RUN, DRAIN, LOAD} state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          ptr_q, ptr_d, gnt_idx, cand;
    logic                    gnt_any, grant_en, issue;
    logic [LOGQH-1:0]        qh_q, qh_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [LAT-1:0]          v_q;
    logic [LAT-1:0][IDW-1:0] id_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= UNCFG;
        else     state_q <= state_d;

    // DRAIN exits on the cycle the last result retires, so LOAD sees an empty unit
    always_comb begin
        state_d = state_q;
        case (state_q)
            UNCFG:   state_d = cfg_valid_i ? LOAD : UNCFG;
            RUN:     state_d = cfg_valid_i ? DRAIN : RUN;
            DRAIN:   state_d = (cnt_d == '0) ? LOAD : DRAIN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        grant_en    = (state_q == RUN) && !cfg_valid_i;
        cfg_ready_o = (state_q == LOAD);
    end

    // first valid requester at or after ptr, wrapping
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!gnt_any && req_valid_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        issue       = grant_en && gnt_any;
        req_ready_o = issue ? (NREQ'(1) << gnt_idx) : '0;
        cu_C_o      = issue ? req_C_i[gnt_idx*LOGQ +: LOGQ] : '0;
        ptr_d       = issue ? ((gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1) : ptr_q;
        qh_d        = (state_q == LOAD) ? cfg_qH_i : qh_q;
        cnt_d       = (issue && !rsp_valid_o) ? cnt_q + 1'b1 :
                      (!issue && rsp_valid_o) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ptr_q <= '0;
            qh_q  <= '0;
            cnt_q <= '0;
            v_q   <= '0;
            id_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            qh_q     <= qh_d;
            cnt_q    <= cnt_d;
            v_q[0]   <= issue;
            id_q[0]  <= gnt_idx;
            for (int s = 1; s < LAT; s++) begin
                v_q[s]  <= v_q[s-1];
                id_q[s] <= id_q[s-1];
            end
        end

    assign rsp_valid_o = v_q[LAT-1];
    assign rsp_id_o    = id_q[LAT-1];
    assign rsp_T_o     = cu_T_i;
    assign cu_qH_o     = qh_q;
    assign busy_o      = (cnt_q != '0);
endmodule

// File: tb/tb_correction_sched.sv
// tb_correction_sched: directed scoreboard bench for correction_sched with a behavioural 3-cycle correction unit
module tb_correction_sched;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [255:0] req_C = '0;
    logic [3:0]   req_ready;
    logic         cfg_valid = 1'b0;
    logic [16:0]  cfg_qH = '0;
    logic         cfg_ready;
    logic [16:0]  cu_qH;
    logic [63:0]  cu_C, cu_T, rsp_T;
    logic         rsp_valid, busy;
    logic [1:0]   rsp_id;

    correction_sched #(.LOGQ(64), .LOGQH(17), .NREQ(4), .LAT(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_C_i(req_C), .req_ready_o(req_ready),
        .cfg_valid_i(cfg_valid), .cfg_qH_i(cfg_qH), .cfg_ready_o(cfg_ready),
        .cu_qH_o(cu_qH), .cu_C_o(cu_C), .cu_T_i(cu_T),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_T_o(rsp_T),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    // correction unit stand-in: T = C >= q ? C - q : C, q = qH*2^47 + 1, three register stages
    function automatic logic [63:0] corr(input logic [63:0] c, input logic [16:0] qh);
        logic [63:0] q;
        q = {qh, 47'd0} + 64'd1;
        return (c >= q) ? c - q : c;
    endfunction

    logic [63:0] m0 = '0, m1 = '0, m2 = '0;
    always @(posedge clk) begin
        m0 <= corr(cu_C, cu_qH);
        m1 <= m0;
        m2 <= m1;
    end
    assign cu_T = m2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] t;
        int          cyc;
    } sb_t;
    sb_t sb[$];
    sb_t mon_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input logic [63:0] t);
        sb_t e;
        e.id  = 2'(id);
        e.t   = t;
        e.cyc = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic set_c(input int i, input logic [63:0] v);
        req_C[i*64 +: 64] = v;
    endtask

    task automatic nx;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 0);
        chk({tag, "_cfg_ready"}, 64'(cfg_ready), 0);
        chk({tag, "_cu_qH"}, 64'(cu_qH), 0);
        chk({tag, "_cu_C"}, cu_C, 0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
        chk({tag, "_rsp_id"}, 64'(rsp_id), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got id=%0d T=%0h want no response (cycle %0d)", rsp_id, rsp_T, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
                chk("rsp_T", rsp_T, mon_e.t);
                chk("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    int g[8] = '{3, 0, 1, 2, 3, 0, 1, 2};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        rst = 1'b0;

        // UNCFG gating then first qH load
        req_valid = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("uncfg_req_ready", 64'(req_ready), 0);
            nx();
        end
        req_valid = '0;
        cfg_qH = 17'd1;
        cfg_valid = 1'b1;
        @(negedge clk);
        chk("cfg_ready_seen", 64'(cfg_ready), 0);
        nx();
        @(negedge clk);
        chk("cfg_ready_load", 64'(cfg_ready), 1);
        chk("cu_qH_during_load", 64'(cu_qH), 0);
        nx();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("cfg_ready_after", 64'(cfg_ready), 0);
        chk("cu_qH_loaded", 64'(cu_qH), 1);
        nx();

        // correction arithmetic from requester 2
        req_valid = 4'b0100;
        set_c(2, 64'h0000_8000_0000_0005);
        push(2, 64'd4);
        @(negedge clk);
        chk("s2_grant0", 64'(req_ready), 64'b0100);
        nx();
        set_c(2, 64'd3);
        push(2, 64'd3);
        @(negedge clk);
        chk("s2_grant1", 64'(req_ready), 64'b0100);
        nx();
        req_valid = '0;
        repeat (4) nx();

        // all four valid, ptr left at 3 by requester 2
        for (int i = 0; i < 4; i++) set_c(i, 64'(100 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            push(g[k], 64'(100 + g[k]));
            @(negedge clk);
            chk("rr_grant", 64'(req_ready), 64'(1) << g[k]);
            nx();
        end
        req_valid = '0;
        repeat (4) nx();

        // reload to qH=2 with three in flight
        req_valid = 4'b0010;
        set_c(1, 64'h0000_8000_0000_0001);
        push(1, 64'd0);
        @(negedge clk); chk("s4_grant0", 64'(req_ready), 64'b0010); nx();
        set_c(1, 64'h0000_8000_0000_000A);
        push(1, 64'd9);
        @(negedge clk); chk("s4_grant1", 64'(req_ready), 64'b0010); nx();
        set_c(1, 64'd7);
        push(1, 64'd7);
        @(negedge clk); chk("s4_grant2", 64'(req_ready), 64'b0010); nx();
        set_c(1, 64'h0001_0000_0000_0001);
        cfg_qH = 17'd2;
        cfg_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("reload_no_grant", 64'(req_ready), 0);
            chk("reload_cfg_ready", 64'(cfg_ready), 64'(k == 3));
            chk("reload_old_qH", 64'(cu_qH), 1);
            nx();
        end
        cfg_valid = 1'b0;
        push(1, 64'd0);
        @(negedge clk);
        chk("s4_grant_new", 64'(req_ready), 64'b0010);
        chk("reload_new_qH", 64'(cu_qH), 2);
        nx();
        set_c(1, 64'h0000_8000_0000_0001);
        push(1, 64'h0000_8000_0000_0001);
        @(negedge clk); chk("s4_grant_new1", 64'(req_ready), 64'b0010); nx();
        req_valid = '0;
        repeat (4) nx();

        // single-requester stream: count saturates at 3, then drains
        req_valid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            set_c(0, 64'(50 + k));
            push(0, 64'(50 + k));
            @(negedge clk);
            chk("s6_grant", 64'(req_ready), 64'b0001);
            if (k >= 1) chk("s6_busy", 64'(busy), 1);
            nx();
        end
        req_valid = '0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk("s6_drain_busy", 64'(busy), 64'(j < 4));
            nx();
        end

        // async reset with two operations in flight
        req_valid = 4'b0001;
        set_c(0, 64'd20);
        @(negedge clk); chk("s5_grant0", 64'(req_ready), 64'b0001); nx();
        set_c(0, 64'd21);
        @(negedge clk); chk("s5_grant1", 64'(req_ready), 64'b0001); nx();
        chk("s5_busy_before", 64'(busy), 1);
        #1;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        #1;
        rst = 1'b0;
        req_valid = '0;
        sb.delete();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 64'(rsp_valid), 0);
            chk("post_rst_busy", 64'(busy), 0);
            nx();
        end

        chk("sb_drained", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
